// File: rtl/strobe_monitor.sv
// strobe_monitor: measures strobe period, locks onto EXP_PERIOD +/- TOL and flags early/late strobes.
// Define STROBE_MONITOR_ERRCNT_EN to enable the saturating error event counter on err_cnt_o.
module strobe_monitor #(
   parameter int CNT_BW     = 8,
   parameter int EXP_PERIOD = 10,
   parameter int TOL        = 1,
   parameter int LOCK_COUNT = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              strobe_i,
   output logic [CNT_BW-1:0] period_o,
   output logic              period_valid_o,
   output logic              locked_o,
   output logic              err_early_o,
   output logic              err_late_o,
   output logic [7:0]        err_cnt_o
);
   localparam int LO = EXP_PERIOD - TOL;
   localparam int HI = EXP_PERIOD + TOL;
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_BW-1:0] HI_CNT = CNT_BW'(HI);

   if (HI >= 2**CNT_BW - 1) begin : g_chk
      $error("strobe_monitor: EXP_PERIOD+TOL must be below 2^CNT_BW-1");
   end

   typedef enum logic [1:0] {WAIT_FIRST, ACQUIRE, LOCKED} state_t;

   state_t            state, state_n;
   logic [CNT_BW-1:0] cnt, meas, period_n;
   logic [MW-1:0]     match, match_n;
   logic              timeout, early, late, in_win;
   logic              period_valid_n, locked_n, early_n, late_n;

   always_comb begin
      meas    = (&cnt) ? cnt : cnt + CNT_BW'(enable_i);
      timeout = enable_i && !strobe_i && cnt == HI_CNT;
      early   = int'(meas) < LO;
      late    = int'(meas) > HI;
      in_win  = !early && !late;
   end

   // counter saturates so a dead strobe never wraps into a false in-window period
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         cnt <= '0;
      else if (strobe_i)
         cnt <= '0;
      else if (enable_i && !(&cnt))
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= WAIT_FIRST;
         match          <= '0;
         period_o       <= '0;
         period_valid_o <= 1'b0;
         locked_o       <= 1'b0;
         err_early_o    <= 1'b0;
         err_late_o     <= 1'b0;
      end else begin
         state          <= state_n;
         match          <= match_n;
         period_o       <= period_n;
         period_valid_o <= period_valid_n;
         locked_o       <= locked_n;
         err_early_o    <= early_n;
         err_late_o     <= late_n;
      end
   end

   // a strobe always wins over a coincident timeout
   always_comb begin
      state_n = state;
      match_n = match;
      if (strobe_i) begin
         case (state)
            WAIT_FIRST: begin
               state_n = ACQUIRE;
               match_n = '0;
            end
            ACQUIRE: begin
               match_n = in_win ? match + 1'b1 : '0;
               state_n = (in_win && match_n == MW'(LOCK_COUNT)) ? LOCKED : ACQUIRE;
            end
            LOCKED: begin
               state_n = in_win ? LOCKED : ACQUIRE;
               match_n = '0;
            end
            default: begin
               state_n = WAIT_FIRST;
               match_n = '0;
            end
         endcase
      end else if (timeout) begin
         state_n = WAIT_FIRST;
         match_n = '0;
      end
   end

   always_comb begin
      period_valid_n = strobe_i && state != WAIT_FIRST;
      period_n       = period_valid_n ? meas : period_o;
      early_n        = strobe_i && state == LOCKED && early;
      late_n         = state == LOCKED && (strobe_i ? late : timeout);
      locked_n       = state_n == LOCKED;
   end

`ifdef STROBE_MONITOR_ERRCNT_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         err_cnt_o <= '0;
      else if ((early_n || late_n) && !(&err_cnt_o))
         err_cnt_o <= err_cnt_o + 1'b1;
   end
`else
   assign err_cnt_o = '0;
`endif
endmodule

// File: doc/strobe_monitor.md
STROBE_MONITOR -- requirements
Module: strobe_monitor

Interface
REQ-001 SHALL have parameter CNT_BW, default 8: width of the interval counter and of period_o.
REQ-002 SHALL have parameter EXP_PERIOD, default 10: expected strobe period in enabled cycles.
REQ-003 SHALL have parameter TOL, default 1: accepted period window is EXP_PERIOD-TOL to EXP_PERIOD+TOL inclusive.
REQ-004 SHALL have parameter LOCK_COUNT, default 3: consecutive in-window periods required to lock.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port enable_i, input, 1 bit: qualifies cycles counted toward the period.
REQ-008 SHALL have port strobe_i, input, 1 bit: monitored strobe, one-cycle pulses.
REQ-009 SHALL have port period_o, output, CNT_BW bits: last measured period.
REQ-010 SHALL have port period_valid_o, output, 1 bit: one-cycle pulse when period_o updates.
REQ-011 SHALL have port locked_o, output, 1 bit: high while in LOCKED.
REQ-012 SHALL have port err_early_o, output, 1 bit: one-cycle pulse on a short period while LOCKED.
REQ-013 SHALL have port err_late_o, output, 1 bit: one-cycle pulse on a long or missing period while LOCKED.
REQ-014 SHALL have port err_cnt_o, output, 8 bits: saturating error event count.

Function
REQ-015 The block SHALL implement three states: WAIT_FIRST, ACQUIRE and LOCKED; all outputs SHALL be registered.
REQ-016 The interval counter SHALL increment on every cycle with enable_i=1 and strobe_i=0, saturating at 2^CNT_BW-1.
REQ-017 strobe_i SHALL be sampled every cycle regardless of enable_i; on a strobe, measured period = counter + enable_i, and the counter clears to 0.
REQ-018 In WAIT_FIRST, a strobe SHALL start measurement and move the state to ACQUIRE without asserting period_valid_o.
REQ-019 In ACQUIRE or LOCKED, a strobe SHALL update period_o and pulse period_valid_o on the next cycle.
REQ-020 In ACQUIRE, an in-window period SHALL increment the match count; reaching LOCK_COUNT SHALL enter LOCKED, and locked_o SHALL rise on the cycle after that strobe.
REQ-021 In ACQUIRE, an out-of-window period SHALL clear the match count, remain in ACQUIRE and raise no error flag.
REQ-022 In LOCKED, a period below the window SHALL pulse err_early_o, and a period above the window SHALL pulse err_late_o; either event SHALL move the state to ACQUIRE with match count 0.
REQ-023 Timeout SHALL occur when the counter equals EXP_PERIOD+TOL with enable_i=1 and strobe_i=0: the state SHALL move to WAIT_FIRST, and err_late_o SHALL pulse if the state was LOCKED.
REQ-024 A strobe in the same cycle as a timeout condition SHALL take priority, and the period SHALL be classified by REQ-022.
REQ-025 A strobe with enable_i=0 and counter=0 SHALL measure period 0, which is early.
REQ-026 EXP_PERIOD+TOL SHALL be less than 2^CNT_BW-1, checked at elaboration.

Reset
REQ-027 rst_i=0 SHALL asynchronously force: state WAIT_FIRST, counter 0, match count 0, period_o 0, and all flags and err_cnt_o 0.
REQ-028 Reset asserted mid-operation SHALL discard any partial measurement, so the first strobe after release yields no period_valid_o.

Configuration
REQ-029 With macro STROBE_MONITOR_ERRCNT_EN defined, err_cnt_o SHALL increment by 1 on each err_early_o or err_late_o pulse and saturate at 255.
REQ-030 Without STROBE_MONITOR_ERRCNT_EN, err_cnt_o SHALL be constant 0, no counter logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
Defaults apply, enable_i=1 unless stated.
REQ-031 Reset released, strobes every 10 clocks -> no period_valid_o on strobe 1; strobes 2-4 give period_o=10; locked_o=1 the cycle after strobe 4.
REQ-032 Locked, next strobe after 8 clocks -> period_o=8, err_early_o pulse, locked_o=0, err_cnt_o=1 (macro on).
REQ-033 Locked, strobes stop -> err_late_o pulse when the counter hits 11, state WAIT_FIRST; the next strobe gives no period_valid_o.
REQ-034 enable_i alternating 1/0, strobes every 20 clocks -> period_o=10 each time, lock acquired and held.
REQ-035 Locked, rst_i low for 1 cycle mid-interval -> all outputs 0 immediately; relock needs 1+3 strobes.
REQ-036 300 forced early errors -> err_cnt_o=255 with macro; err_cnt_o=0 throughout without it.
